// File: rtl/ifu_fetch_buf.sv
// Purpose: sequential instruction fetch unit; owns the fetch PC, issues one
//          outstanding request at a time, and buffers responses in a DEPTH-entry FIFO.
// Latency: request accepted at t, response at t+k (k>=1), out_valid at t+k+1.
// Backpressure: a fetch is issued only when a FIFO slot is reserved for its response,
//          so the FIFO never overflows. out_ready low stalls fetching once DEPTH entries are held.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   redirect_valid/redirect_pc    flush the FIFO, squash the in-flight fetch, load a new PC
//   mem_req_valid/ready/addr      fetch request channel
//   mem_rsp_valid/ready/data/err  fetch response channel
//   out_valid/ready/pc/inst/err   FIFO head toward the decode unit
module ifu_fetch_buf #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned     DEPTH    = 4,
  parameter int unsigned     PC_STEP  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_rsp_valid,
  output logic            mem_rsp_ready,
  input  logic [XLEN-1:0] mem_rsp_data,
  input  logic            mem_rsp_err,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_inst,
  output logic            out_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]  req_pc_q, req_pc_d;    // address of the request in flight
  logic             drop_q, drop_d;        // in-flight response must be discarded
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

  logic [XLEN-1:0]  fifo_pc_q   [DEPTH];
  logic [XLEN-1:0]  fifo_inst_q [DEPTH];
  logic             fifo_err_q  [DEPTH];

  logic push;
  logic pop;
  logic redirect_lsb_unused;

  // Instructions are word aligned; the low redirect bits carry no information.
  assign redirect_lsb_unused = ^redirect_pc[1:0];

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    drop_d     = drop_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;

    // A redirect voids both a same-cycle push and a same-cycle pop.
    push = (state_q == S_WAIT) && mem_rsp_valid && !drop_q && !redirect_valid;
    pop  = (count_q != '0) && out_ready && !redirect_valid;

    if (redirect_valid) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (!redirect_valid && (count_q < DEPTH_C)) state_d = S_REQ;
      end
      S_REQ: begin
        if (mem_req_ready) begin
          state_d = S_WAIT;
          // A squashed request must not advance the PC past the redirect target.
          if (!drop_q && !redirect_valid) fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
        end
      end
      S_WAIT: begin
        if (mem_rsp_valid) begin
          drop_d  = 1'b0;
          // count_d already holds this response, so a new request always has a slot.
          state_d = (count_d < DEPTH_C) ? S_REQ : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
      // A request cannot be withdrawn, so its eventual response is marked for discard.
      // A response landing in the redirect cycle is consumed here, so nothing stays pending.
      if (state_q == S_REQ) drop_d = 1'b1;
      if ((state_q == S_WAIT) && !mem_rsp_valid) drop_d = 1'b1;
    end

    // Latch the request address on entry to REQ so it stays stable across a
    // redirect that arrives while the request is stalled.
    if ((state_d == S_REQ) && (state_q != S_REQ)) req_pc_d = fetch_pc_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
      drop_q     <= 1'b0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      drop_q     <= drop_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only visible when count_q covers them.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      fifo_pc_q[wr_ptr_q]   <= req_pc_q;
      fifo_inst_q[wr_ptr_q] <= mem_rsp_data;
      fifo_err_q[wr_ptr_q]  <= mem_rsp_err;
    end
  end

  assign mem_req_valid = (state_q == S_REQ);
  assign mem_req_addr  = req_pc_q;
  assign mem_rsp_ready = (state_q == S_WAIT);

  assign out_valid = (count_q != '0);
  assign out_pc    = out_valid ? fifo_pc_q[rd_ptr_q]   : '0;
  assign out_inst  = out_valid ? fifo_inst_q[rd_ptr_q] : '0;
  assign out_err   = out_valid ? fifo_err_q[rd_ptr_q]  : 1'b0;

endmodule
